// File: rtl/seq_shift_mul_unit.sv
// Sequential shift-add multiplier and one-bit-per-cycle shifter for the 8 x 8-bit register file.
// Accepts one operation from IDLE, iterates in BUSY, then issues a single write strobe in DONE.
module seq_shift_mul_unit (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [2:0] OPCODE,
   input  logic [7:0] OPERAND1,
   input  logic [7:0] OPERAND2,
   input  logic [2:0] DEST_IN,
   output logic [7:0] RESULT,
   output logic [2:0] DEST_OUT,
   output logic       WRITE,
   output logic       BUSY,
   output logic       ERROR
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   localparam logic [2:0] OP_MUL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   state_t     state;
   state_t     state_next;
   logic [7:0] mcand;
   logic [7:0] mplier;
   logic [7:0] acc;
   logic [2:0] op;
   logic [2:0] dest;
   logic [3:0] count;
   logic       op_valid;
   logic       accept;

   assign op_valid = (OPCODE <= OP_ROR);
   assign accept   = (state == S_IDLE) && START && op_valid;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // WRITE and BUSY are decoded straight from the state so they can never lag it.
   always_comb begin
      state_next = state;
      WRITE      = 1'b0;
      BUSY       = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            BUSY = 1'b1;
            if (count == 4'd0) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            BUSY       = 1'b1;
            WRITE      = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // For shifts the multiplicand register doubles as the shift register, so RESULT
   // is taken from acc for MUL and from mcand otherwise.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mcand    <= 8'h00;
         mplier   <= 8'h00;
         acc      <= 8'h00;
         op       <= 3'b000;
         dest     <= 3'b000;
         count    <= 4'd0;
         RESULT   <= 8'h00;
         DEST_OUT <= 3'b000;
         ERROR    <= 1'b0;
      end else begin
         ERROR <= (state == S_IDLE) && START && !op_valid;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mcand  <= OPERAND1;
                  mplier <= OPERAND2;
                  op     <= OPCODE;
                  dest   <= DEST_IN;
                  acc    <= 8'h00;
                  count  <= (OPCODE == OP_MUL) ? 4'd8 : {1'b0, OPERAND2[2:0]};
               end
            end
            S_BUSY: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
                  case (op)
                     OP_MUL: begin
                        if (mplier[0]) begin
                           acc <= acc + mcand;
                        end
                        mcand  <= {mcand[6:0], 1'b0};
                        mplier <= {1'b0, mplier[7:1]};
                     end
                     OP_SLL:  mcand <= {mcand[6:0], 1'b0};
                     OP_SRL:  mcand <= {1'b0, mcand[7:1]};
                     OP_SRA:  mcand <= {mcand[7], mcand[7:1]};
                     OP_ROR:  mcand <= {mcand[0], mcand[7:1]};
                     default: mcand <= mcand;
                  endcase
               end else begin
                  RESULT   <= (op == OP_MUL) ? acc : mcand;
                  DEST_OUT <= dest;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_mul_unit.sv
// Self-checking bench for seq_shift_mul_unit: a cycle-level behavioural model checked every
// cycle, directed cases pinned to hand-computed values, and randomized operation streams.
module tb_seq_shift_mul_unit;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       START;
   logic [2:0] OPCODE;
   logic [7:0] OPERAND1;
   logic [7:0] OPERAND2;
   logic [2:0] DEST_IN;
   logic [7:0] RESULT;
   logic [2:0] DEST_OUT;
   logic       WRITE;
   logic       BUSY;
   logic       ERROR;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 0;

   int         m_cyc = 0;
   logic [7:0] m_res = 8'h00;
   logic [2:0] m_dest = 3'b000;
   logic       m_err = 1'b0;
   logic [7:0] m_pend_res = 8'h00;
   logic [2:0] m_pend_dest = 3'b000;

   seq_shift_mul_unit dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .OPCODE   (OPCODE),
      .OPERAND1 (OPERAND1),
      .OPERAND2 (OPERAND2),
      .DEST_IN  (DEST_IN),
      .RESULT   (RESULT),
      .DEST_OUT (DEST_OUT),
      .WRITE    (WRITE),
      .BUSY     (BUSY),
      .ERROR    (ERROR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0]       prod;
      logic [15:0]       dbl;
      logic signed [7:0] s;
      int                k;
      k    = int'(b[2:0]);
      prod = 16'(a) * 16'(b);
      dbl  = {a, a} >> k;
      s    = a;
      case (op)
         3'd0:    return prod[7:0];
         3'd1:    return a << k;
         3'd2:    return a >> k;
         3'd3:    return 8'(s >>> k);
         default: return dbl[7:0];
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [7:0] b);
      return (op == 3'd0) ? 9 : int'(b[2:0]) + 1;
   endfunction

   // Model: m_cyc counts cycles left in the operation; the last one (m_cyc==1) is the write cycle.
   always @(posedge CLK) begin
      if (RESET) begin
         m_cyc  <= 0;
         m_res  <= 8'h00;
         m_dest <= 3'b000;
         m_err  <= 1'b0;
      end else begin
         m_err <= 1'b0;
         if (m_cyc == 0) begin
            if (START && OPCODE <= 3'd4) begin
               m_cyc       <= ref_latency(OPCODE, OPERAND2) + 1;
               m_pend_res  <= ref_result(OPCODE, OPERAND1, OPERAND2);
               m_pend_dest <= DEST_IN;
            end else if (START) begin
               m_err <= 1'b1;
            end
         end else begin
            if (m_cyc == 2) begin
               m_res  <= m_pend_res;
               m_dest <= m_pend_dest;
            end
            m_cyc <= m_cyc - 1;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         vectors++;
         if (BUSY !== (m_cyc != 0) || WRITE !== (m_cyc == 1) || ERROR !== m_err ||
             RESULT !== m_res || DEST_OUT !== m_dest) begin
            miscompares++;
            $display("[TB] FAIL cycle_model t=%0t busy=%b/%b write=%b/%b error=%b/%b result=%h/%h dest=%0d/%0d (actual/required)",
                     $time, BUSY, (m_cyc != 0), WRITE, (m_cyc == 1), ERROR, m_err, RESULT, m_res, DEST_OUT, m_dest);
         end
      end
   end

   task automatic check_output(input string name, input int actual, input int required);
      vectors++;
      if (actual != required) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] dest, input bit repulse,
                                 output int lat, output logic [7:0] res, output logic [2:0] dst);
      bit seen;
      @(negedge CLK);
      START = 1'b1; OPCODE = op; OPERAND1 = a; OPERAND2 = b; DEST_IN = dest;
      @(posedge CLK);
      #1;
      START = 1'b0; OPCODE = 3'($urandom); OPERAND1 = 8'($urandom); OPERAND2 = 8'($urandom); DEST_IN = 3'($urandom);
      lat = 0; res = 8'h00; dst = 3'b000; seen = 0;
      while (!seen && lat <= 20) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
         if (WRITE) begin
            seen = 1;
            res  = RESULT;
            dst  = DEST_OUT;
         end else begin
            START  = repulse && (lat == 3);
            OPCODE = 3'd1;
         end
      end
      START = 1'b0;
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL write_timeout actual=no WRITE required=WRITE within 20 cycles");
         lat = -1;
      end
   endtask

   task automatic run_check(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] dest, input bit repulse, input int exp_lat, input int exp_res);
      int         lat;
      logic [7:0] res;
      logic [2:0] dst;
      apply_stimulus(op, a, b, dest, repulse, lat, res, dst);
      check_output({name, "_latency"}, lat, exp_lat);
      check_output({name, "_result"}, int'(res), exp_res);
      check_output({name, "_dest"}, int'(dst), int'(dest));
   endtask

   task automatic invalid_op(input logic [2:0] op);
      @(negedge CLK);
      START = 1'b1; OPCODE = op; OPERAND1 = 8'($urandom); OPERAND2 = 8'($urandom); DEST_IN = 3'($urandom);
      @(posedge CLK);
      #1;
      START = 1'b0;
      @(negedge CLK);
      check_output("invalid_error_pulse", int'(ERROR), 1);
      check_output("invalid_busy", int'(BUSY), 0);
      check_output("invalid_write", int'(WRITE), 0);
      @(negedge CLK);
      check_output("invalid_error_clear", int'(ERROR), 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit         wr_seen;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      RESET = 1'b1; START = 1'b0; OPCODE = 3'b000; OPERAND1 = 8'h00; OPERAND2 = 8'h00; DEST_IN = 3'b000;
      repeat (3) @(posedge CLK);
      #1;
      RESET  = 1'b0;
      chk_en = 1;
      @(negedge CLK);
      check_output("reset_result", int'(RESULT), 0);
      check_output("reset_busy", int'(BUSY), 0);

      run_check("mul_7x6", 3'd0, 8'd7, 8'd6, 3'd3, 0, 9, 42);
      run_check("mul_20x15", 3'd0, 8'd20, 8'd15, 3'd5, 0, 9, 8'h2C);
      run_check("mul_0x255", 3'd0, 8'd0, 8'd255, 3'd1, 0, 9, 0);
      run_check("sra_90_3", 3'd3, 8'h90, 8'd3, 3'd2, 0, 4, 8'hF2);
      run_check("srl_90_3", 3'd2, 8'h90, 8'd3, 3'd4, 0, 4, 8'h12);
      run_check("sll_81_1", 3'd1, 8'h81, 8'd1, 3'd6, 0, 2, 8'h02);
      run_check("ror_81_1", 3'd4, 8'h81, 8'd1, 3'd7, 0, 2, 8'hC0);
      run_check("sll_by_0", 3'd1, 8'hA5, 8'hF8, 3'd0, 0, 1, 8'hA5);
      run_check("mul_repulse", 3'd0, 8'd13, 8'd11, 3'd2, 1, 9, 143);

      // Abort a MUL with RESET sampled at edge N+4.
      @(negedge CLK);
      START = 1'b1; OPCODE = 3'd0; OPERAND1 = 8'd9; OPERAND2 = 8'd9; DEST_IN = 3'd5;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      check_output("abort_result", int'(RESULT), 0);
      check_output("abort_dest", int'(DEST_OUT), 0);
      check_output("abort_busy", int'(BUSY), 0);
      check_output("abort_write", int'(WRITE), 0);
      wr_seen = 0;
      repeat (15) begin
         @(negedge CLK);
         if (WRITE) wr_seen = 1;
      end
      check_output("abort_no_late_write", int'(wr_seen), 0);
      run_check("after_abort_mul", 3'd0, 8'd9, 8'd9, 3'd5, 0, 9, 81);

      invalid_op(3'b110);

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         b  = 8'($urandom);
         if (op > 3'd4) begin
            invalid_op(op);
         end else begin
            run_check("random_op", op, a, b, 3'($urandom), ($urandom_range(0, 3) == 0),
                      ref_latency(op, b), int'(ref_result(op, a, b)));
         end
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      repeat (3) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_shift_mul_unit.md
SEQ_SHIFT_MUL_UNIT -- requirements
Module: seq_shift_mul_unit

Interface
Parameters: none; data width fixed at 8 bits to match the 8 x 8-bit register file.
REQ-001: The block SHALL use clock CLK and reset RESET (synchronous, active-high); all state SHALL change only on posedge CLK.
REQ-002: CLK  input  1  system clock.
REQ-003: RESET  input  1  synchronous active-high reset.
REQ-004: START  input  1  request to begin an operation; sampled on posedge CLK.
REQ-005: OPCODE  input  3  000 MUL, 001 SLL, 010 SRL, 011 SRA, 100 ROR; 101-111 invalid.
REQ-006: OPERAND1  input  8  multiplicand or value to shift; driven from register file OUT1.
REQ-007: OPERAND2  input  8  multiplier (MUL) or shift amount in OPERAND2[2:0] (shifts); driven from register file OUT2.
REQ-008: DEST_IN  input  3  destination register address for the result.
REQ-009: RESULT  output  8  computed value; feeds register file IN.
REQ-010: DEST_OUT  output  3  latched destination; feeds register file INADDRESS.
REQ-011: WRITE  output  1  one-cycle write strobe; feeds register file WRITE.
REQ-012: BUSY  output  1  high while an accepted operation is in progress, including its write cycle; the control unit stalls the PC on BUSY.
REQ-013: ERROR  output  1  one-cycle pulse flagging an invalid opcode.

Function
REQ-014: The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015: In IDLE with START=1 and a valid OPCODE, the edge SHALL latch OPERAND1, OPERAND2, OPCODE and DEST_IN, load the iteration count (8 for MUL, OPERAND2[2:0] for shifts) and enter BUSY.
REQ-016: In BUSY with count>0, each edge SHALL perform exactly one iteration and decrement the count by 1.
REQ-017: In BUSY with count=0, the edge SHALL enter DONE.
REQ-018: Latency: with START captured at edge N, MUL SHALL enter DONE at edge N+9, and a shift by k SHALL enter DONE at edge N+k+1 (k=0 enters at N+1).
REQ-019: MUL SHALL use shift-add: when the multiplier LSB is 1, add the multiplicand into the accumulator; then shift the multiplicand left by 1 and the multiplier right by 1. RESULT SHALL be the low 8 bits of the product, with overflow discarded.
REQ-020: Each iteration SHALL shift by one bit: SLL shifts left with zero fill; SRL shifts right with zero fill; SRA shifts right replicating bit 7; ROR rotates bit 0 into bit 7.
REQ-021: In DONE, WRITE SHALL be 1 for exactly one cycle with RESULT and DEST_OUT valid; the next edge SHALL return to IDLE.
REQ-022: BUSY SHALL be 1 in the BUSY and DONE states and 0 in IDLE.
REQ-023: RESULT and DEST_OUT SHALL hold their last values until the next DONE; WRITE SHALL be 0 outside DONE.
REQ-024: START while BUSY=1 SHALL be ignored, with no effect on state, operands or outputs.
REQ-025: START in IDLE with an invalid OPCODE SHALL produce ERROR=1 for the following cycle only, remain in IDLE, and produce no WRITE.
REQ-026: Operand inputs SHALL be don't-care after the capture edge; the computation SHALL use only the latched copies.

Reset
REQ-027: On RESET=1 at posedge CLK: state IDLE; RESULT=8'h00, DEST_OUT=3'b000, WRITE=0, BUSY=0, ERROR=0; internal accumulator and count cleared.
REQ-028: RESET SHALL take priority over START and over any in-flight operation; an aborted operation SHALL produce no WRITE.
REQ-029: Back-to-back operation SHALL be supported: START asserted in the first IDLE cycle after DONE SHALL be accepted.

Verification
REQ-030: MUL 7 x 6, DEST_IN=3, START at edge N -> WRITE=1 in the cycle after edge N+9, RESULT=42, DEST_OUT=3, BUSY=1 from N+1 to N+9.
REQ-031: MUL 20 x 15 -> RESULT=8'h2C (300 mod 256); MUL 0 x 255 -> RESULT=0; both complete at N+9.
REQ-032: SRA 8'h90 by 3 -> RESULT=8'hF2 at N+4; SRL 8'h90 by 3 -> 8'h12; SLL 8'h81 by 1 -> 8'h02; ROR 8'h81 by 1 -> 8'hC0.
REQ-033: Shift with OPERAND2[2:0]=0 -> DONE at N+1, RESULT=OPERAND1; START re-pulsed mid-MUL -> ignored, result unchanged.
REQ-034: RESET asserted at N+4 of a MUL -> the next cycle shows all outputs zero, no WRITE ever issued, and a new START is accepted normally.
REQ-035: OPCODE=3'b110 with START -> ERROR=1 for one cycle, BUSY=0, WRITE=0 throughout.
